// File: rtl/kbd_scode_dec_if.sv
// kbd_scode_dec_if -- key-event stream between the scan-code decoder and
// its consumer.
//   ev_valid : head event present (source -> sink)
//   ev_ready : sink accepts the head event (sink -> source)
//   ev_code  : key code, final byte of the sequence
//   ev_ext   : sequence carried the E0 prefix (or is Pause)
//   ev_brk   : 1 = break (release), 0 = make
interface kbd_scode_dec_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_brk;

    modport master (output ev_valid, output ev_code, output ev_ext, output ev_brk,
                    input  ev_ready);
    modport slave  (input  ev_valid, input  ev_code, input  ev_ext, input  ev_brk,
                    output ev_ready);
endinterface

// File: rtl/kbd_scode_dec.sv
// kbd_scode_dec -- PS/2 Set-2 scan-code sequence decoder.
// Turns raw received bytes (E0 / F0 / E1 multi-byte sequences) into single
// key events, queues them in a show-ahead FIFO and tracks modifier keys.
//   clk, rst    : clock, asynchronous active-high reset
//   scode       : received byte, valid while scode_en is high (one cycle)
//   rx_abort    : receiver error pulse; abandons a partial sequence
//   ev          : event stream (valid/ready, code, ext, brk)
//   mods        : {ralt,lalt,rctrl,lctrl,rshift,lshift} live levels
//   ovf/ovf_clr : sticky "event dropped on full FIFO" flag and its clear
//   sync_lost   : one-cycle pulse when a partial sequence is abandoned
module kbd_scode_dec #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             scode,
    input  logic                   scode_en,
    input  logic                   rx_abort,
    kbd_scode_dec_if.master        ev,
    output logic [5:0]             mods,
    output logic                   ovf,
    input  logic                   ovf_clr,
    output logic                   sync_lost
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    pause_cnt_q, pause_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          sync_lost_q, sync_lost_d;
    logic [5:0]    mods_q, mods_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          commit, c_ext, c_brk, from_idle;
    logic [7:0]    c_code;
    logic          full, pop, push_ok;
    logic [9:0]    head;
    logic [9:0]    mem [FIFO_DEPTH];

    // Sequence parser
    always_comb begin
        state_d     = state_q;
        pause_cnt_d = pause_cnt_q;
        tmo_d       = tmo_q;
        sync_lost_d = 1'b0;
        commit      = 1'b0;
        c_ext       = 1'b0;
        c_brk       = 1'b0;
        c_code      = scode;
        from_idle   = 1'b0;
        if (state_q != S_IDLE && (rx_abort || (!scode_en && tmo_q == TMO_LAST))) begin
            // abandon wins over a byte arriving in the same cycle
            state_d     = S_IDLE;
            tmo_d       = '0;
            sync_lost_d = 1'b1;
        end else if (scode_en) begin
            tmo_d = '0;
            case (state_q)
                S_IDLE: from_idle = 1'b1;
                S_EXT: begin
                    if (scode == 8'hF0)                         state_d = S_EXT_BRK;
                    else if (scode == 8'hE0)                    state_d = S_EXT;
                    else if (scode == 8'h12 || scode == 8'h59)  state_d = S_IDLE; // fake shift
                    else begin
                        commit  = 1'b1;
                        c_ext   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_BRK: begin
                    if (scode == 8'hE0 || scode == 8'hF0) begin
                        sync_lost_d = 1'b1;
                        from_idle   = 1'b1;
                    end else begin
                        commit  = 1'b1;
                        c_brk   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_EXT_BRK: begin
                    if (scode == 8'hE0 || scode == 8'hF0 || scode == 8'hE1) begin
                        sync_lost_d = 1'b1;
                        from_idle   = 1'b1;
                    end else if (scode == 8'h12 || scode == 8'h59) begin
                        state_d = S_IDLE;                              // fake shift release
                    end else begin
                        commit  = 1'b1;
                        c_ext   = 1'b1;
                        c_brk   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_PAUSE: begin
                    // byte contents are irrelevant; only the count matters
                    if (pause_cnt_q == 3'd1) begin
                        commit  = 1'b1;
                        c_ext   = 1'b1;
                        c_code  = 8'hE1;
                        state_d = S_IDLE;
                    end
                    pause_cnt_d = pause_cnt_q - 3'd1;
                end
                default: state_d = S_IDLE;
            endcase
            if (from_idle) begin
                case (scode)
                    8'hE0: state_d = S_EXT;
                    8'hF0: state_d = S_BRK;
                    8'hE1: begin
                        state_d     = S_PAUSE;
                        pause_cnt_d = 3'd7;
                    end
                    8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: state_d = S_IDLE;
                    default: begin
                        commit  = 1'b1;
                        state_d = S_IDLE;
                    end
                endcase
            end
        end else if (state_q != S_IDLE) begin
            tmo_d = tmo_q + 1'b1;
        end else begin
            tmo_d = '0;
        end
    end

    // Modifier tracking and FIFO control
    always_comb begin
        mods_d = mods_q;
        if (commit) begin
            case ({c_ext, c_code})
                9'h012: mods_d[0] = ~c_brk;
                9'h059: mods_d[1] = ~c_brk;
                9'h014: mods_d[2] = ~c_brk;
                9'h114: mods_d[3] = ~c_brk;
                9'h011: mods_d[4] = ~c_brk;
                9'h111: mods_d[5] = ~c_brk;
                default: mods_d = mods_q;
            endcase
        end
        full    = (count_q == CW'(FIFO_DEPTH));
        pop     = ev.ev_valid & ev.ev_ready;
        // a pop in the same cycle frees the slot the push needs
        push_ok = commit & (~full | pop);
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop)      count_d = count_q + 1'b1;
        else if (!push_ok && pop) count_d = count_q - 1'b1;
        // a new overflow beats a simultaneous clear
        ovf_d = ovf_q;
        if (commit && full && !pop) ovf_d = 1'b1;
        else if (ovf_clr)           ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pause_cnt_q <= '0;
            tmo_q       <= '0;
            sync_lost_q <= 1'b0;
            mods_q      <= '0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pause_cnt_q <= pause_cnt_d;
            tmo_q       <= tmo_d;
            sync_lost_q <= sync_lost_d;
            mods_q      <= mods_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage is unreset; outputs are gated by ev_valid so stale entries
    // never show after reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= {c_ext, c_brk, c_code};
    end

    // Show-ahead: head is read combinationally from the read pointer.
    assign head        = mem[rd_ptr_q];
    assign ev.ev_valid = (count_q != '0);
    assign ev.ev_code  = ev.ev_valid ? head[7:0] : 8'h00;
    assign ev.ev_brk   = ev.ev_valid & head[8];
    assign ev.ev_ext   = ev.ev_valid & head[9];
    assign mods        = mods_q;
    assign ovf         = ovf_q;
    assign sync_lost   = sync_lost_q;
endmodule

// File: tb/tb_kbd_scode_dec.sv
module tb_kbd_scode_dec;
    localparam int DEPTH = 8;
    localparam int TMO   = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] scode = 8'h00;
    logic       scode_en = 1'b0;
    logic       rx_abort = 1'b0;
    logic [5:0] mods;
    logic       ovf;
    logic       ovf_clr = 1'b0;
    logic       sync_lost;

    int n_checks = 0;
    int n_errs   = 0;

    kbd_scode_dec_if ev_if ();

    kbd_scode_dec #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .scode     (scode),
        .scode_en  (scode_en),
        .rx_abort  (rx_abort),
        .ev        (ev_if),
        .mods      (mods),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .sync_lost (sync_lost)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // {valid, ext, brk, code} as one word
    function automatic logic [31:0] ev_word();
        return {21'd0, ev_if.ev_valid, ev_if.ev_ext, ev_if.ev_brk, ev_if.ev_code};
    endfunction

    // Drive one byte for one cycle; returns at the negedge after the edge
    // that consumed it, where a committed event is already visible.
    task automatic send_byte(input logic [7:0] b);
        scode    = b;
        scode_en = 1'b1;
        @(negedge clk);
        scode_en = 1'b0;
    endtask

    task automatic expect_pop(input string tag, input logic ext, input logic brk,
                              input logic [7:0] code);
        check_eq(tag, ev_word(), {21'd0, 1'b1, ext, brk, code});
        ev_if.ev_ready = 1'b1;
        @(negedge clk);
        ev_if.ev_ready = 1'b0;
    endtask

    logic [7:0] fill_codes [9];

    initial begin
        ev_if.ev_ready = 1'b0;
        fill_codes = '{8'h15, 8'h16, 8'h1D, 8'h1E, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
        repeat (2) @(negedge clk);
        check_eq("rst_ev",   ev_word(), 32'h0);
        check_eq("rst_mods", {26'd0, mods}, 32'h0);
        check_eq("rst_ovf",  {31'd0, ovf}, 32'h0);
        check_eq("rst_sync", {31'd0, sync_lost}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Simple make code and pop
        send_byte(8'h1C);
        expect_pop("make_1c", 1'b0, 1'b0, 8'h1C);
        check_eq("after_pop_empty", {31'd0, ev_if.ev_valid}, 32'h0);

        // Extended break, fake shift
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        expect_pop("ext_brk_75", 1'b1, 1'b1, 8'h75);
        send_byte(8'hE0); send_byte(8'h12);
        check_eq("fake_shift_noev", {31'd0, ev_if.ev_valid}, 32'h0);
        check_eq("fake_shift_mods", {26'd0, mods}, 32'h0);

        // Modifiers
        send_byte(8'h12);
        check_eq("mods_lshift", {26'd0, mods}, 32'h01);
        send_byte(8'hF0); send_byte(8'h12);
        check_eq("mods_clear", {26'd0, mods}, 32'h00);
        send_byte(8'hE0); send_byte(8'h11);
        check_eq("mods_ralt", {26'd0, mods}, 32'h20);
        expect_pop("mod_ev0", 1'b0, 1'b0, 8'h12);
        expect_pop("mod_ev1", 1'b0, 1'b1, 8'h12);
        expect_pop("mod_ev2", 1'b1, 1'b0, 8'h11);
        check_eq("mod_empty", {31'd0, ev_if.ev_valid}, 32'h0);

        // Overflow
        for (int i = 0; i < 8; i++) send_byte(fill_codes[i]);
        check_eq("full_no_ovf", {31'd0, ovf}, 32'h0);
        send_byte(fill_codes[8]);
        check_eq("ovf_set", {31'd0, ovf}, 32'h1);
        ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
        check_eq("ovf_cleared", {31'd0, ovf}, 32'h0);
        ovf_clr = 1'b1; send_byte(8'h27); ovf_clr = 1'b0;
        check_eq("ovf_clr_vs_set", {31'd0, ovf}, 32'h1);
        ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
        ev_if.ev_ready = 1'b1; send_byte(8'h26); ev_if.ev_ready = 1'b0;
        check_eq("pushpop_no_ovf", {31'd0, ovf}, 32'h0);
        for (int i = 1; i < 8; i++) expect_pop("drain", 1'b0, 1'b0, fill_codes[i]);
        expect_pop("drain_last", 1'b0, 1'b0, 8'h26);
        check_eq("drain_empty", {31'd0, ev_if.ev_valid}, 32'h0);

        // Timeout
        send_byte(8'hE0);
        repeat (TMO - 1) @(negedge clk);
        check_eq("tmo_not_yet", {31'd0, sync_lost}, 32'h0);
        @(negedge clk);
        check_eq("tmo_pulse", {31'd0, sync_lost}, 32'h1);
        @(negedge clk);
        check_eq("tmo_pulse_end", {31'd0, sync_lost}, 32'h0);
        send_byte(8'h1C);
        expect_pop("after_tmo", 1'b0, 1'b0, 8'h1C);

        // rx_abort
        send_byte(8'hF0);
        rx_abort = 1'b1; @(negedge clk); rx_abort = 1'b0;
        check_eq("abort_pulse", {31'd0, sync_lost}, 32'h1);
        check_eq("abort_noev", {31'd0, ev_if.ev_valid}, 32'h0);
        send_byte(8'h1C);
        expect_pop("after_abort", 1'b0, 1'b0, 8'h1C);
        send_byte(8'hF0);
        rx_abort = 1'b1; send_byte(8'h1C); rx_abort = 1'b0;
        check_eq("abort_prio_noev", {31'd0, ev_if.ev_valid}, 32'h0);
        send_byte(8'h1C);
        expect_pop("after_abort2", 1'b0, 1'b0, 8'h1C);

        // BRK restart on prefix
        send_byte(8'hF0); send_byte(8'hE0);
        check_eq("restart_pulse", {31'd0, sync_lost}, 32'h1);
        send_byte(8'h75);
        expect_pop("restart_ev", 1'b1, 1'b0, 8'h75);

        // Pause
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0);
        check_eq("pause_7_noev", {31'd0, ev_if.ev_valid}, 32'h0);
        send_byte(8'h77);
        expect_pop("pause_ev", 1'b1, 1'b0, 8'hE1);
        check_eq("pause_single", {31'd0, ev_if.ev_valid}, 32'h0);
        check_eq("pause_mods", {26'd0, mods}, 32'h20);

        // Async reset mid-sequence with a queued event
        send_byte(8'h1C); send_byte(8'hE1); send_byte(8'h14);
        #1 rst = 1'b1;
        #1;
        check_eq("mid_rst_ev",   ev_word(), 32'h0);
        check_eq("mid_rst_mods", {26'd0, mods}, 32'h0);
        check_eq("mid_rst_ovf",  {31'd0, ovf}, 32'h0);
        check_eq("mid_rst_sync", {31'd0, sync_lost}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_byte(8'h1C);
        expect_pop("post_rst", 1'b0, 1'b0, 8'h1C);
        check_eq("post_rst_empty", {31'd0, ev_if.ev_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule
